// File: rtl/x_top_mem_slave.sv
// UART-side target of the x_top_mem bridge: decodes serial command frames into 32-bit
// valid/accept memory transactions and returns ack or read-data bytes. Includes its UART rx/tx.

module x_top_uart_rx #(
    parameter int unsigned p_clk_hz = 1000000,
    parameter int unsigned p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);
    localparam int unsigned c_div   = p_clk_hz / p_baud;
    localparam int unsigned c_half  = (c_div / 2 > 0) ? c_div / 2 : 1;
    localparam int unsigned c_div_w = $clog2(c_div + 1);

    typedef enum logic [1:0] {r_idle, r_start, r_data, r_stop} rx_state_t;

    rx_state_t            state;
    logic                 rx_s1, rx_s2;
    logic [c_div_w-1:0]   div_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shreg;

    // Start edge is re-checked half a bit in, then every bit is sampled mid-period.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= r_idle;
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            rx_s1   <= i_rx;
            rx_s2   <= rx_s1;
            o_valid <= 1'b0;
            unique case (state)
                r_idle: begin
                    div_cnt <= '0;
                    if (!rx_s2) state <= r_start;
                end
                r_start: begin
                    if (div_cnt == c_div_w'(c_half - 1)) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s2 ? r_idle : r_data;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                r_data: begin
                    if (div_cnt == c_div_w'(c_div - 1)) begin
                        div_cnt <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        if (bit_cnt == 3'd7) state <= r_stop;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                r_stop: begin
                    if (div_cnt == c_div_w'(c_div - 1)) begin
                        if (rx_s2) begin
                            o_valid <= 1'b1;
                            o_data  <= shreg;
                        end
                        state <= r_idle;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module x_top_uart_tx #(
    parameter int unsigned p_clk_hz = 1000000,
    parameter int unsigned p_baud   = 9600
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_accept_c,
    output logic       o_tx
);
    localparam int unsigned c_div   = p_clk_hz / p_baud;
    localparam int unsigned c_div_w = $clog2(c_div + 1);

    logic               busy;
    logic [9:0]         shreg;
    logic [3:0]         bit_cnt;
    logic [c_div_w-1:0] div_cnt;

    assign o_accept_c = i_valid & ~busy;

    // Frame is {stop, data, start}; shreg[0] is the bit currently on the line.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            busy    <= 1'b0;
            shreg   <= '1;
            bit_cnt <= '0;
            div_cnt <= '0;
            o_tx    <= 1'b1;
        end else if (o_accept_c) begin
            busy    <= 1'b1;
            shreg   <= {1'b1, i_data, 1'b0};
            bit_cnt <= '0;
            div_cnt <= '0;
            o_tx    <= 1'b0;
        end else if (busy) begin
            if (div_cnt == c_div_w'(c_div - 1)) begin
                div_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                    o_tx <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= {1'b1, shreg[9:1]};
                    o_tx    <= shreg[1];
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

module x_top_mem_slave #(
    parameter int unsigned p_clk_hz  = 1000000,
    parameter int unsigned p_baud    = 9600,
    parameter int unsigned p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_rnw,
    output logic        o_valid,
    input  logic        i_accept,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_err
);
    typedef enum logic [2:0] {s_idle, s_addr, s_wdata, s_ack, s_mem, s_rsend} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  idx_nx;
    logic        cmd_rd;
    logic        final_ack;
    logic [31:0] rdata;
    logic [31:0] tmo_cnt;
    logic        tmo_hit_c;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_accept_c;
    logic        rx_valid;
    logic [7:0]  rx_data;

    x_top_uart_rx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_rx (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_rx    (i_rx),
        .o_valid (rx_valid),
        .o_data  (rx_data)
    );

    x_top_uart_tx #(.p_clk_hz(p_clk_hz), .p_baud(p_baud)) u_tx (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_valid    (tx_req),
        .i_data     (tx_data),
        .o_accept_c (tx_accept_c),
        .o_tx       (o_tx)
    );

    assign idx_nx    = idx + 2'd1;
    assign tmo_hit_c = (p_timeout != 0) && (tmo_cnt == 32'(p_timeout - 1));

    // Frame decoder; a received byte always takes priority over timeout expiry.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= s_idle;
            idx       <= '0;
            cmd_rd    <= 1'b0;
            final_ack <= 1'b0;
            rdata     <= '0;
            tmo_cnt   <= '0;
            tx_req    <= 1'b0;
            tx_data   <= '0;
            o_rnw     <= 1'b0;
            o_valid   <= 1'b0;
            o_addr    <= '0;
            o_data    <= '0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_err <= 1'b0;
            unique case (state)
                s_idle: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h00 || rx_data == 8'h01) begin
                            state   <= s_addr;
                            cmd_rd  <= rx_data[0];
                            idx     <= '0;
                            tmo_cnt <= '0;
                            o_busy  <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                s_addr: begin
                    if (rx_valid) begin
                        o_addr[{idx, 3'b000} +: 8] <= rx_data;
                        tmo_cnt <= '0;
                        if (idx == 2'd3) begin
                            idx <= '0;
                            if (cmd_rd) begin
                                state   <= s_mem;
                                o_valid <= 1'b1;
                                o_rnw   <= 1'b1;
                            end else begin
                                state <= s_wdata;
                            end
                        end else begin
                            idx <= idx_nx;
                        end
                    end else if (tmo_hit_c) begin
                        state  <= s_idle;
                        idx    <= '0;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                s_wdata: begin
                    if (rx_valid) begin
                        o_data[{idx, 3'b000} +: 8] <= rx_data;
                        tmo_cnt <= '0;
                        if (idx == 2'd3) begin
                            state   <= s_mem;
                            idx     <= '0;
                            o_valid <= 1'b1;
                            o_rnw   <= 1'b0;
                        end else begin
                            state     <= s_ack;
                            final_ack <= 1'b0;
                            tx_req    <= 1'b1;
                            tx_data   <= 8'h00;
                        end
                    end else if (tmo_hit_c) begin
                        state  <= s_idle;
                        idx    <= '0;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                s_ack: begin
                    if (rx_valid) o_err <= 1'b1;
                    if (tx_accept_c) begin
                        tx_req <= 1'b0;
                        if (final_ack) begin
                            state  <= s_idle;
                            idx    <= '0;
                            o_busy <= 1'b0;
                        end else begin
                            state   <= s_wdata;
                            idx     <= idx_nx;
                            tmo_cnt <= '0;
                        end
                    end
                end
                s_mem: begin
                    if (rx_valid) o_err <= 1'b1;
                    if (i_accept) begin
                        o_valid <= 1'b0;
                        idx     <= '0;
                        tx_req  <= 1'b1;
                        if (cmd_rd) begin
                            state   <= s_rsend;
                            rdata   <= i_data;
                            tx_data <= i_data[7:0];
                        end else begin
                            state     <= s_ack;
                            final_ack <= 1'b1;
                            tx_data   <= 8'h00;
                        end
                    end
                end
                s_rsend: begin
                    if (rx_valid) o_err <= 1'b1;
                    if (tx_accept_c) begin
                        if (idx == 2'd3) begin
                            state  <= s_idle;
                            idx    <= '0;
                            tx_req <= 1'b0;
                            o_busy <= 1'b0;
                        end else begin
                            idx     <= idx_nx;
                            tx_data <= rdata[{idx_nx, 3'b000} +: 8];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_x_top_mem_slave.sv
// Directed bench for x_top_mem_slave: a host UART driver, a tx byte monitor and a
// stalling memory responder, with hand-computed expectations.

module tb_x_top_mem_slave;
    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        i_rx = 1'b1;
    logic        i_accept = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_tx, o_rnw, o_valid, o_busy, o_err;
    logic [31:0] o_addr, o_data;

    localparam int unsigned c_bit = 5;

    x_top_mem_slave #(.p_clk_hz(1000000), .p_baud(200000), .p_timeout(200)) dut (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_rx     (i_rx),
        .o_tx     (o_tx),
        .o_rnw    (o_rnw),
        .o_valid  (o_valid),
        .i_accept (i_accept),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .i_data   (i_data),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    int         n_vec = 0;
    int         n_bad = 0;
    int         n_err = 0;
    int         n_req = 0;
    logic       valid_d = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] mon_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Error pulses and rising request edges.
    always @(negedge i_clk) begin
        if (o_err === 1'b1) n_err++;
        if (o_valid === 1'b1 && valid_d !== 1'b1) n_req++;
        valid_d = o_valid;
    end

    // Host-side UART receiver for o_tx.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_nrst && o_tx === 1'b0) begin
                repeat (2) @(negedge i_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_bit) @(negedge i_clk);
                    mon_b[i] = o_tx;
                end
                repeat (c_bit) @(negedge i_clk);
                txq.push_back(mon_b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx = 1'b0;
        repeat (c_bit) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (c_bit) @(negedge i_clk);
        end
        i_rx = 1'b1;
        repeat (c_bit - 1) @(negedge i_clk);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int t = 0;
        while (txq.size() < n && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        chk(tag, 32'(txq.size()), 32'(n));
    endtask

    task automatic wait_valid();
        int t = 0;
        while (o_valid !== 1'b1 && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        chk("mem_req", 32'(o_valid), 32'd1);
    endtask

    task automatic mem_resp(input int stall, input logic [31:0] rd,
                            output logic [31:0] ga, output logic [31:0] gd, output logic gr);
        wait_valid();
        ga = o_addr;
        gd = o_data;
        gr = o_rnw;
        repeat (stall) @(negedge i_clk);
        chk("mem_hold", 32'({o_valid, o_addr == ga, o_data == gd}), 32'd7);
        chk("line_idle", 32'(o_tx), 32'd1);
        i_accept = 1'b1;
        i_data   = rd;
        @(negedge i_clk);
        i_accept = 1'b0;
        i_data   = '0;
        chk("mem_drop", 32'(o_valid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int stall);
        logic [31:0] ga, gd;
        logic        gr;
        int          r0;
        txq.delete();
        r0 = n_req;
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        send_byte(d[7:0]);
        wait_tx(1, "wr_ack0");
        send_byte(d[15:8]);
        wait_tx(2, "wr_ack1");
        send_byte(d[23:16]);
        wait_tx(3, "wr_ack2");
        send_byte(d[31:24]);
        mem_resp(stall, 32'h0, ga, gd, gr);
        chk("wr_addr", ga, a);
        chk("wr_data", gd, d);
        chk("wr_rnw", 32'(gr), 32'd0);
        wait_tx(4, "wr_ack3");
        for (int i = 0; i < 4; i++) chk("wr_ackval", 32'(txq[i]), 32'h0);
        chk("wr_nreq", 32'(n_req - r0), 32'd1);
        chk("wr_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_rnw"}, 32'(o_rnw), 32'd0);
        chk({tag, "_addr"}, o_addr, 32'h0);
        chk({tag, "_data"}, o_data, 32'h0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
        chk({tag, "_tx"}, 32'(o_tx), 32'd1);
    endtask

    initial begin
        logic [31:0] ga, gd;
        logic        gr;
        int          e0, r0, t;

        repeat (3) @(negedge i_clk);
        chk_reset_state("rst");
        i_nrst = 1'b1;
        repeat (5) @(negedge i_clk);

        // Write with a 5-clock memory stall.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 5);

        // Read with a 3-clock stall.
        txq.delete();
        send_read(32'h0000_0004);
        mem_resp(3, 32'h1234_5678, ga, gd, gr);
        chk("rd_addr", ga, 32'h0000_0004);
        chk("rd_rnw", 32'(gr), 32'd1);
        wait_tx(4, "rd_bytes");
        chk("rd_b0", 32'(txq[0]), 32'h78);
        chk("rd_b1", 32'(txq[1]), 32'h56);
        chk("rd_b2", 32'(txq[2]), 32'h34);
        chk("rd_b3", 32'(txq[3]), 32'h12);
        repeat (5) @(negedge i_clk);
        chk("rd_busy", 32'(o_busy), 32'd0);

        // Unknown command byte, then a good write.
        txq.delete();
        e0 = n_err;
        r0 = n_req;
        send_byte(8'h7F);
        repeat (80) @(negedge i_clk);
        chk("bad_err", 32'(n_err - e0), 32'd1);
        chk("bad_tx", 32'(txq.size()), 32'd0);
        chk("bad_req", 32'(n_req - r0), 32'd0);
        chk("bad_busy", 32'(o_busy), 32'd0);
        do_write(32'h0000_0100, 32'h0102_0304, 1);

        // Inter-byte timeout in ADDR.
        e0 = n_err;
        r0 = n_req;
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        t = 0;
        while (o_err !== 1'b1 && t < 400) begin
            @(negedge i_clk);
            t++;
            if (t == 150) chk("tmo_busy_mid", 32'(o_busy), 32'd1);
        end
        chk("tmo_window", 32'(t >= 190 && t <= 212), 32'd1);
        @(negedge i_clk);
        chk("tmo_err", 32'(n_err - e0), 32'd1);
        chk("tmo_busy", 32'(o_busy), 32'd0);
        chk("tmo_req", 32'(n_req - r0), 32'd0);

        // Extra host byte during RSEND.
        txq.delete();
        e0 = n_err;
        send_read(32'h0000_0020);
        mem_resp(2, 32'hA1B2_C3D4, ga, gd, gr);
        send_byte(8'h55);
        chk("rs_busy", 32'(o_busy), 32'd1);
        wait_tx(4, "rs_bytes");
        chk("rs_b0", 32'(txq[0]), 32'hD4);
        chk("rs_b1", 32'(txq[1]), 32'hC3);
        chk("rs_b2", 32'(txq[2]), 32'hB2);
        chk("rs_b3", 32'(txq[3]), 32'hA1);
        chk("rs_err", 32'(n_err - e0), 32'd1);

        // Reset mid-ADDR.
        send_byte(8'h00);
        send_byte(8'h10);
        @(negedge i_clk);
        i_nrst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_state("rst_addr");
        i_nrst = 1'b1;
        repeat (5) @(negedge i_clk);

        // Reset while the memory request is pending.
        send_read(32'h0000_0030);
        wait_valid();
        repeat (2) @(negedge i_clk);
        i_nrst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_state("rst_mem");
        i_nrst = 1'b1;
        repeat (5) @(negedge i_clk);
        do_write(32'h0000_0044, 32'hCAFE_F00D, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
